char_t: RTL and testbench

- UART transmitter: serialises one 8-bit character per request onto a single TX line. Frame format is start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits.
- Runs on the 23.04 MHz system clock and uses the same 3-bit baud-select encoding as the UART receive path, so RX and TX share one baud setting.
- Sits between the character source (command/response logic) and the TX pad.

---
 rtl/uart_pkg.sv | 46 ++++
 rtl/uart_bit_timer.sv | 29 ++
 rtl/char_t.sv | 137 +++++++++++++
 tb/tb_char_t.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, baud tables, parity modes.
// Used by both the TX and RX paths so they agree on timing.
package uart_pkg;
  localparam int CNT_W = 13;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  function automatic logic [CNT_W-1:0] baud_period(
    input logic [2:0] sel
  );
    case (sel)
      3'd0:    baud_period = 13'd100;
      3'd1:    baud_period = 13'd200;
      3'd2:    baud_period = 13'd400;
      3'd3:    baud_period = 13'd600;
      3'd4:    baud_period = 13'd1200;
      3'd5:    baud_period = 13'd2400;
      default: baud_period = 13'd4800;
    endcase
  endfunction

  // 1.5 bit periods: RX samples mid-bit after the start edge
  function automatic logic [CNT_W-1:0] baud_period_1p5(
    input logic [2:0] sel
  );
    case (sel)
      3'd0:    baud_period_1p5 = 13'd150;
      3'd1:    baud_period_1p5 = 13'd300;
      3'd2:    baud_period_1p5 = 13'd600;
      3'd3:    baud_period_1p5 = 13'd900;
      3'd4:    baud_period_1p5 = 13'd1800;
      3'd5:    baud_period_1p5 = 13'd3600;
      default: baud_period_1p5 = 13'd7200;
    endcase
  endfunction
endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..P-1, pulses bit_end_o on P-1.
// restart_i holds the count at zero (idle or re-sync).
import uart_pkg::*;

module uart_bit_timer (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             restart_i,
  input  logic [CNT_W-1:0] period_i,
  output logic             bit_end_o
);
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign bit_end_o = !restart_i &&
    (cnt_q == period_i - CNT_W'(1));

  // next count: wrap at bit end, clear on restart
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (restart_i || bit_end_o) cnt_d = '0;
  end

  // count register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
endmodule

// File: rtl/char_t.sv
// UART transmitter: start, 8 data LSB first, opt parity, stops.
// Character and bit period are latched at accept.
import uart_pkg::*;

module char_t #(
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [2:0] i_baud,
  input  logic [7:0] i_char,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_finished
);
  localparam int PMODE =
    (PARITY == PAR_EVEN || PARITY == PAR_ODD) ?
    PARITY : PAR_NONE;
  localparam logic PAR_EN  = (PMODE != PAR_NONE);
  localparam logic PAR_INV = (PMODE == PAR_ODD);
  localparam logic [2:0] STOP_LAST =
    (STOP_BITS == 2) ? 3'd1 : 3'd0;

  uart_state_e      state_q, state_d;
  logic [7:0]       char_q, char_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [2:0]       idx_q, idx_d;
  logic             tx_q, tx_d;
  logic             fin_q, fin_d;
  logic             restart;
  logic             bit_end;

  assign restart = (state_q == ST_IDLE);

  uart_bit_timer u_timer (
    .clk_i     (i_clk),
    .rst_ni    (i_rst),
    .restart_i (restart),
    .period_i  (per_q),
    .bit_end_o (bit_end)
  );

  // next-state and next tx level, computed one cycle ahead
  always_comb begin
    state_d = state_q;
    char_d  = char_q;
    per_d   = per_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    fin_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (i_valid) begin
          char_d  = i_char;
          per_d   = baud_period(i_baud);
          idx_d   = 3'd0;
          tx_d    = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          idx_d   = 3'd0;
          tx_d    = char_q[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
            idx_d = 3'd0;
            if (PAR_EN) begin
              state_d = ST_PARITY;
              tx_d    = (^char_q) ^ PAR_INV;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = char_q[idx_d];
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          idx_d   = 3'd0;
          tx_d    = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (idx_q == STOP_LAST) begin
            state_d = ST_IDLE;
            idx_d   = 3'd0;
            fin_d   = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // state and datapath registers; tx resets high at once
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      char_q  <= '0;
      per_q   <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      char_q  <= char_d;
      per_q   <= per_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      fin_q   <= fin_d;
    end
  end

  assign o_ready    = (state_q == ST_IDLE);
  assign o_busy     = (state_q != ST_IDLE);
  assign o_tx       = tx_q;
  assign o_finished = fin_q;
endmodule

// File: tb/tb_char_t.sv
// Directed bench for char_t: three parity/stop variants.
// Frames are checked at the first and last cycle of every bit.
module tb_char_t;
  logic       clk;
  logic       rst_n;
  logic [2:0] baud;
  logic [7:0] chr;
  logic [2:0] vld;
  logic [2:0] rdy, tx, busy, fin;
  int         errors;
  int         checks;
  int         nfin0;
  int         snap;

  char_t #(.PARITY(0), .STOP_BITS(1)) u0 (
    .i_clk(clk), .i_rst(rst_n), .i_baud(baud),
    .i_char(chr), .i_valid(vld[0]), .o_ready(rdy[0]),
    .o_tx(tx[0]), .o_busy(busy[0]), .o_finished(fin[0])
  );
  char_t #(.PARITY(1), .STOP_BITS(1)) u1 (
    .i_clk(clk), .i_rst(rst_n), .i_baud(baud),
    .i_char(chr), .i_valid(vld[1]), .o_ready(rdy[1]),
    .o_tx(tx[1]), .o_busy(busy[1]), .o_finished(fin[1])
  );
  char_t #(.PARITY(2), .STOP_BITS(2)) u2 (
    .i_clk(clk), .i_rst(rst_n), .i_baud(baud),
    .i_char(chr), .i_valid(vld[2]), .o_ready(rdy[2]),
    .o_tx(tx[2]), .o_busy(busy[2]), .o_finished(fin[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (fin[0]) nfin0 <= nfin0 + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic send(input int s, input logic [7:0] c,
                      input logic [2:0] b);
    chk("ready_before_send", {31'd0, rdy[s]}, 1);
    chk("tx_idle_before_send", {31'd0, tx[s]}, 1);
    chk("busy_before_send", {31'd0, busy[s]}, 0);
    chk("fin_before_send", {31'd0, fin[s]}, 0);
    chk("rdy_before_send", {31'd0, rdy[s]}, 1);
    chr = c;
    baud = b;
    vld[s] = 1'b1;
    tick();
    vld[s] = 1'b0;
  endtask

  // Called in cycle t+1 of a frame accepted at edge t;
  // returns in cycle t+L+1 after checking completion.
  task automatic frame(input int s, input logic [7:0] c,
                       input int p, input bit haspar,
                       input logic pbit, input int stops,
                       input bit mess);
    logic lv [12];
    int   ln [12];
    int   n;
    lv[0] = 1'b0;
    ln[0] = p;
    for (int i = 0; i < 8; i++) begin
      lv[i+1] = c[i];
      ln[i+1] = p;
    end
    n = 9;
    if (haspar) begin
      lv[n] = pbit;
      ln[n] = p;
      n++;
    end
    lv[n] = 1'b1;
    ln[n] = p * stops;
    n++;
    for (int i = 0; i < n; i++) begin
      if (mess && i > 0) begin
        baud = 3'd0;
        chr = ~c;
        vld[s] = (i < n - 1) ? i[0] : 1'b0;
      end
      chk($sformatf("bit%0d_first", i),
          {31'd0, tx[s]}, {31'd0, lv[i]});
      chk($sformatf("busy%0d", i), {31'd0, busy[s]}, 1);
      repeat (ln[i] - 1) tick();
      chk($sformatf("bit%0d_last", i),
          {31'd0, tx[s]}, {31'd0, lv[i]});
      chk($sformatf("nofin%0d", i), {31'd0, fin[s]}, 0);
      tick();
    end
    chk("fin_pulse", {31'd0, fin[s]}, 1);
    chk("ready_at_fin", {31'd0, rdy[s]}, 1);
    chk("busy_at_fin", {31'd0, busy[s]}, 0);
    chk("tx_at_fin", {31'd0, tx[s]}, 1);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    nfin0 = 0;
    baud = 3'd0;
    chr = 8'h00;
    vld = 3'b111;
    rst_n = 1'b0;
    repeat (5) tick();
    for (int s = 0; s < 3; s++) begin
      chk("rst_tx", {31'd0, tx[s]}, 1);
      chk("rst_ready", {31'd0, rdy[s]}, 1);
      chk("rst_busy", {31'd0, busy[s]}, 0);
      chk("rst_fin", {31'd0, fin[s]}, 0);
    end
    vld = 3'b000;
    rst_n = 1'b1;
    repeat (3) tick();

    // 0xA3 at 115200 on each variant
    send(0, 8'hA3, 3'd1);
    frame(0, 8'hA3, 200, 1'b0, 1'b0, 1, 1'b0);
    tick();
    chk("fin_one_cycle", {31'd0, fin[0]}, 0);
    send(1, 8'hA3, 3'd1);
    frame(1, 8'hA3, 200, 1'b1, 1'b0, 1, 1'b0);
    tick();
    chk("fin_one_cycle_even", {31'd0, fin[1]}, 0);
    send(2, 8'hA3, 3'd1);
    frame(2, 8'hA3, 200, 1'b1, 1'b1, 2, 1'b0);
    tick();
    chk("fin_one_cycle_odd", {31'd0, fin[2]}, 0);

    // 0x55 at 230400
    snap = nfin0;
    send(0, 8'h55, 3'd0);
    frame(0, 8'h55, 100, 1'b0, 1'b0, 1, 1'b0);
    tick();
    chk("fin_55_once", nfin0 - snap, 1);
    chk("fin_55_low", {31'd0, fin[0]}, 0);

    // back-to-back 0x00 then 0xFF, valid held
    snap = nfin0;
    chr = 8'h00;
    baud = 3'd0;
    vld[0] = 1'b1;
    tick();
    chr = 8'hFF;
    frame(0, 8'h00, 100, 1'b0, 1'b0, 1, 1'b0);
    tick();
    vld[0] = 1'b0;
    frame(0, 8'hFF, 100, 1'b0, 1'b0, 1, 1'b0);
    repeat (5) tick();
    chk("b2b_two_fins", nfin0 - snap, 2);
    chk("b2b_idle_tx", {31'd0, tx[0]}, 1);

    // inputs churn mid-frame; latched values hold
    snap = nfin0;
    send(0, 8'h3C, 3'd5);
    frame(0, 8'h3C, 2400, 1'b0, 1'b0, 1, 1'b1);
    tick();
    chk("churn_one_fin", nfin0 - snap, 1);
    chk("churn_ready", {31'd0, rdy[0]}, 1);
    send(0, 8'h5A, 3'd0);
    frame(0, 8'h5A, 100, 1'b0, 1'b0, 1, 1'b0);
    tick();

    // slowest rate, MSB last
    send(0, 8'h80, 3'd7);
    frame(0, 8'h80, 4800, 1'b0, 1'b0, 1, 1'b0);
    tick();

    // reset mid-frame
    send(0, 8'h00, 3'd0);
    repeat (149) tick();
    chk("pre_rst_tx_low", {31'd0, tx[0]}, 0);
    snap = nfin0;
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_tx", {31'd0, tx[0]}, 1);
    chk("async_rst_ready", {31'd0, rdy[0]}, 1);
    chk("async_rst_busy", {31'd0, busy[0]}, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (1200) tick();
    chk("rst_no_fin", nfin0 - snap, 0);
    chk("post_rst_tx", {31'd0, tx[0]}, 1);
    chk("post_rst_ready", {31'd0, rdy[0]}, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
